// File: rtl/hex_refresh_ctrl.sv
// hex_refresh_ctrl
// ----------------
// Shares one external 4-bit-to-14-segment decoder across NUM_DISP two-digit
// HEX display pairs. The host writes one 4-bit value per slot into a small
// register file. A scan sequencer then visits the slots round-robin, one slot
// per SCAN_DIV clocks. For each visit it drives the slot value on dec_data,
// gives the external decoder one full cycle, and captures dec_segments into
// that slot's seg_out field.
//
// Parameters
//   NUM_DISP  number of display slots (2..8)
//   SCAN_DIV  clk cycles per scan slot (>= 3)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr_valid      host write request
//   wr_ready      write accepted when wr_valid && wr_ready (low only in LOAD)
//   wr_addr[2:0]  target slot; addresses >= NUM_DISP are accepted and dropped
//   wr_data[3:0]  value 0..15
//   dec_data[3:0] registered value fed to the shared decoder
//   dec_segments  combinational decoder result for dec_data (14 bits)
//   seg_out       slot k at bits [14k+13:14k], active-low, all ones = blank
//   frame_done    one-cycle pulse after the pointer wraps past the last slot
//
// Build option
//   HEX_REFRESH_DIRTY_ONLY_EN  when defined, a slot is only reloaded and
//   resampled if it was written since its last capture; clean slots are
//   skipped without touching dec_data or seg_out.

module hex_refresh_ctrl #(
    parameter int NUM_DISP = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [3:0]               wr_data,
    output logic [3:0]               dec_data,
    input  logic [13:0]              dec_segments,
    output logic [14*NUM_DISP-1:0]   seg_out,
    output logic                     frame_done
);

    localparam int PTR_W = $clog2(NUM_DISP);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DISP - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             scan_tick;
    logic [PTR_W-1:0] ptr;
    logic             ptr_adv;
    logic             load_en;
    logic             sample_en;
    logic [3:0]       val [NUM_DISP];
    logic             wr_fire;
    logic             wr_hit;
    logic [PTR_W-1:0] wr_idx;

`ifdef HEX_REFRESH_DIRTY_ONLY_EN
    logic [NUM_DISP-1:0] dirty;
`endif

    // Host write port. The range check uses the full 3-bit address so that
    // out-of-range slots are dropped rather than aliased onto low slots.
    assign wr_fire = wr_valid && wr_ready;
    assign wr_hit  = wr_fire && ({1'b0, wr_addr} < 4'(NUM_DISP));
    assign wr_idx  = wr_addr[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                val[k] <= 4'd0;
            end
        end else if (wr_hit) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                if (wr_idx == PTR_W'(k)) begin
                    val[k] <= wr_data;
                end
            end
        end
    end

    // Scan prescaler: one tick per SCAN_DIV clocks.
    assign scan_tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (scan_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobes. SCAN_DIV >= 3 guarantees the next tick cannot
    // arrive before SAMPLE has returned to IDLE.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        sample_en  = 1'b0;
        ptr_adv    = 1'b0;
        wr_ready   = 1'b1;
        case (state)
            IDLE: begin
                if (scan_tick) begin
`ifdef HEX_REFRESH_DIRTY_ONLY_EN
                    if (dirty[ptr]) begin
                        state_next = LOAD;
                    end else begin
                        // Clean slot: skip the visit but keep the pointer moving.
                        ptr_adv = 1'b1;
                    end
`else
                    state_next = LOAD;
`endif
                end
            end
            LOAD: begin
                // Hold off the host for the one cycle val[ptr] is being read.
                wr_ready   = 1'b0;
                load_en    = 1'b1;
                state_next = SAMPLE;
            end
            SAMPLE: begin
                sample_en  = 1'b1;
                ptr_adv    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slot pointer and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= ptr_adv && (ptr == PTR_LAST);
            if (ptr_adv) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    // Decoder input register: gives the external decoder a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_data <= 4'd0;
        end else if (load_en) begin
            dec_data <= val[ptr];
        end
    end

    // Segment capture. A write landing in the SAMPLE cycle only changes val;
    // the pattern captured here was decoded from the value loaded in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= '1;
        end else if (sample_en) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                if (ptr == PTR_W'(k)) begin
                    seg_out[14*k +: 14] <= dec_segments;
                end
            end
        end
    end

`ifdef HEX_REFRESH_DIRTY_ONLY_EN
    // Dirty tracking: a write in the same cycle as the slot's SAMPLE wins, so
    // the new value still gets its own visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= '1;
        end else begin
            for (int k = 0; k < NUM_DISP; k++) begin
                if (wr_hit && (wr_idx == PTR_W'(k))) begin
                    dirty[k] <= 1'b1;
                end else if (sample_en && (ptr == PTR_W'(k))) begin
                    dirty[k] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_hex_refresh_ctrl.sv
// Testbench for hex_refresh_ctrl with NUM_DISP=4, SCAN_DIV=4 and an ideal
// two-digit decimal decoder driving dec_segments. Cycle label n is the value
// seen just before the n-th rising edge after reset release (label 0 is the
// reset state). Expected frames are queued by the stimulus; a monitor pops
// one per frame_done pulse.

module tb_hex_refresh_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;

    localparam logic [13:0] D0    = 14'h2040;
    localparam logic [13:0] D9    = 14'h2010;
    localparam logic [13:0] D12   = 14'h3CA4;
    localparam logic [13:0] D15   = 14'h3C92;
    localparam logic [13:0] BLANK = 14'h3FFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [3:0]       wr_data;
    logic [3:0]       dec_data;
    logic [13:0]      dec_segments;
    logic [14*ND-1:0] seg_out;
    logic             frame_done;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [13:0] dec14(input logic [3:0] v);
        int n;
        n = int'(v);
        return {seg7(n / 10), seg7(n % 10)};
    endfunction

    assign dec_segments = dec14(dec_data);

    hex_refresh_ctrl #(
        .NUM_DISP (ND),
        .SCAN_DIV (SD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .dec_data     (dec_data),
        .dec_segments (dec_segments),
        .seg_out      (seg_out),
        .frame_done   (frame_done)
    );

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int               at;
        logic [14*ND-1:0] seg;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int     checks = 0;
    int     errors = 0;
    int     acc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14*ND-1:0] slots(input logic [13:0] s3, input logic [13:0] s2,
                                                input logic [13:0] s1, input logic [13:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("frame_done_unexpected", 64'(frame_done), 64'd0);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_cycle", 64'(cyc), 64'(mon_f.at));
                    check("frame_seg", 64'(seg_out), 64'(mon_f.seg));
                end
            end
        end
    end

    task automatic wait_label(input int l);
        int n;
        n = 0;
        while (cyc != l) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                $display("FAIL wait_label timeout: at cycle %0d, wanted %0d", cyc, l);
                $fatal(1, "wait bound expired");
            end
        end
    endtask

    task automatic write1(input logic [2:0] a, input logic [3:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        check("wr_ready_write", 64'(wr_ready), 64'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'd0;
        repeat (3) @(negedge clk);

        exp_q.push_back('{18, slots(D0, D0, D0, D0)});
        exp_q.push_back('{34, slots(D0, D12, D9, D0)});
        exp_q.push_back('{50, slots(D0, D12, D9, D0)});
        exp_q.push_back('{66, slots(D0, D12, D9, D0)});
        exp_q.push_back('{82, slots(D0, D12, D9, D0)});
        rst_n = 1'b1;

        // Reset state.
        check("reset_seg", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, BLANK)));
        check("reset_wr_ready", 64'(wr_ready), 64'd1);
        check("reset_dec_data", 64'(dec_data), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);

        wait_label(5);
        check("blank_c5", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, BLANK)));
        wait_label(6);
        check("slot0_c6", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, D0)));

        // Two writes in IDLE cycles of frame 1.
        wait_label(22);
        write1(3'd2, 4'd12);
        write1(3'd1, 4'd9);

        // Held write to an out-of-range slot: ready drops only in LOAD cycles.
        wait_label(36);
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 3'd6;
            wr_data  = 4'd15;
            check("wr_ready_hold", 64'(wr_ready), 64'((cyc % 4) != 0));
            if (wr_ready) acc++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("accepted_count", 64'(acc), 64'd15);

        // Write slot 0 in its own SAMPLE cycle.
        wait_label(69);
        write1(3'd0, 4'd15);
        check("slot0_old_c70", 64'(seg_out[13:0]), 64'(D0));
        wait_label(85);
        check("dec_data_new", 64'(dec_data), 64'd15);
        wait_label(86);
        check("slot0_new_c86", 64'(seg_out), 64'(slots(D0, D12, D9, D15)));

        // Reset while slot 3 is in LOAD.
        wait_label(96);
        check("pre_reset_dec", 64'(dec_data), 64'd12);
        check("pre_reset_ready", 64'(wr_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_seg", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, BLANK)));
        check("mid_reset_dec", 64'(dec_data), 64'd0);
        check("mid_reset_ready", 64'(wr_ready), 64'd1);
        check("mid_reset_fd", 64'(frame_done), 64'd0);
        exp_q.push_back('{18, slots(D0, D0, D0, D0)});
        @(negedge clk);
        rst_n = 1'b1;

        wait_label(5);
        check("rst2_blank_c5", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, BLANK)));
        wait_label(6);
        check("rst2_slot0_c6", 64'(seg_out), 64'(slots(BLANK, BLANK, BLANK, D0)));
        wait_label(22);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
